// File: rtl/instr_shift_register_pkg.sv
// Shared data-flow definitions for the serial instruction path and the
// downstream test unit: field widths, field offsets and FSM state encoding.
package instr_shift_register_pkg;

  // Instruction word layout (LSB first on the serial line).
  localparam int WORD_LENGTH_DEF = 20;
  localparam int ADDR_BITS_DEF   = 10;
  localparam int B_BITS_DEF      = 3;
  localparam int SPARE_BITS_DEF  = 1;
  localparam int FUNC_BITS_DEF   = 6;
  localparam int PS_BITS_DEF     = 2;

  // Field offsets inside the assembled word.
  localparam int ADDR_LSB  = 0;
  localparam int B_LSB     = ADDR_LSB + ADDR_BITS_DEF;
  localparam int SPARE_LSB = B_LSB + B_BITS_DEF;
  localparam int FUNC_LSB  = SPARE_LSB + SPARE_BITS_DEF;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } isr_state_e;

endpackage

// File: rtl/instr_shift_register_stage_counter.sv
// stage_counter: free-running stage count while an instruction is held,
// plus the final-stage action pulse for the downstream test unit.
module stage_counter #(
  parameter int PS_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold_active,   // receiver is in HOLD this cycle
  input  logic               hold_stay,     // receiver stays in HOLD next cycle
  output logic [PS_BITS-1:0] ps,
  output logic               action_trigger
);

  // Count up while HOLD persists; any cycle that does not continue HOLD
  // (entry from SHIFT, exit on consume, idle, reset) leaves the count at 0.
  always_ff @(posedge clk) begin
    if (rst || !hold_stay) begin
      ps <= '0;
    end else begin
      ps <= ps + 1'b1;
    end
  end

  // Final stage is the all-ones count; never asserted outside HOLD.
  always_comb begin
    action_trigger = hold_active && (ps == {PS_BITS{1'b1}});
  end

endmodule

// File: rtl/instr_shift_register.sv
// instr_shift_register: assembles a serial LSB-first instruction word,
// decodes it into fields and holds it for the test unit until consumed.
//
// Handshake: ready=1 (IDLE only) means a ser_en&word_start bit will be taken
// as bit 0 of a new word. instr_valid=1 means the field outputs hold a
// complete instruction; the consumer pulses consume for one cycle to release
// it. A word_start arriving while an instruction is held is dropped and
// reported on overrun_err.
module instr_shift_register
  import instr_shift_register_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int B_BITS      = B_BITS_DEF,
  parameter int SPARE_BITS  = SPARE_BITS_DEF,
  parameter int FUNC_BITS   = FUNC_BITS_DEF,
  parameter int PS_BITS     = PS_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ser_in,
  input  logic                  ser_en,
  input  logic                  word_start,
  input  logic                  consume,
  output logic                  ready,
  output logic                  instr_valid,
  output logic [ADDR_BITS-1:0]  instr_addr,
  output logic [B_BITS-1:0]     instr_b,
  output logic [SPARE_BITS-1:0] instr_spare,
  output logic [FUNC_BITS-1:0]  instr_func,
  output logic [PS_BITS-1:0]    ps,
  output logic                  action_trigger,
  output logic                  framing_err,
  output logic                  overrun_err,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = $clog2(WORD_LENGTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LENGTH - 1);

  isr_state_e             state, state_next;
  logic [WORD_LENGTH-1:0] word, word_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   load_fields;
  logic                   framing_next;
  logic                   overrun_next;

  // Next-state, word assembly and error-pulse decisions.
  always_comb begin
    state_next   = state;
    word_next    = word;
    cnt_next     = cnt;
    load_fields  = 1'b0;
    framing_next = 1'b0;
    overrun_next = 1'b0;
    case (state)
      ST_IDLE: begin
        // Bits without word_start are not part of any word: ignore them.
        if (ser_en && word_start) begin
          word_next[0] = ser_in;
          cnt_next     = CNT_W'(1);
          state_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_en) begin
          if (word_start) begin
            // Unexpected start mid-word: resynchronise on the new word.
            word_next[0] = ser_in;
            cnt_next     = CNT_W'(1);
            framing_next = 1'b1;
          end else begin
            word_next[cnt] = ser_in;
            if (cnt == LAST_BIT) begin
              cnt_next    = '0;
              load_fields = 1'b1;
              state_next  = ST_HOLD;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (ser_en && word_start) begin
          overrun_next = 1'b1;
        end
        if (consume) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, shift register, counters and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      word        <= '0;
      cnt         <= '0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_next;
      word        <= word_next;
      cnt         <= cnt_next;
      framing_err <= framing_next;
      overrun_err <= overrun_next;
    end
  end

  // Field outputs update only on the edge that completes a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_addr  <= '0;
      instr_b     <= '0;
      instr_spare <= '0;
      instr_func  <= '0;
    end else if (load_fields) begin
      instr_addr  <= word_next[ADDR_LSB  +: ADDR_BITS];
      instr_b     <= word_next[B_LSB     +: B_BITS];
      instr_spare <= word_next[SPARE_LSB +: SPARE_BITS];
      instr_func  <= word_next[FUNC_LSB  +: FUNC_BITS];
    end
  end

  // Status outputs are pure functions of the current state.
  always_comb begin
    ready       = (state == ST_IDLE);
    instr_valid = (state == ST_HOLD);
    state_dbg   = state;
  end

  stage_counter #(
    .PS_BITS (PS_BITS)
  ) u_stage_counter (
    .clk            (clk),
    .rst            (rst),
    .hold_active    (state == ST_HOLD),
    .hold_stay      ((state == ST_HOLD) && (state_next == ST_HOLD)),
    .ps             (ps),
    .action_trigger (action_trigger)
  );

endmodule

// File: tb/tb_instr_shift_register.sv
// Bench for instr_shift_register: directed serial words, a behavioural
// model of the receiver, a per-cycle compare and hand-computed literals.
module tb_instr_shift_register;
  import instr_shift_register_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst, ser_in, ser_en, word_start, consume;
  logic       ready, instr_valid, action_trigger, framing_err, overrun_err;
  logic [9:0] instr_addr;
  logic [2:0] instr_b;
  logic [0:0] instr_spare;
  logic [5:0] instr_func;
  logic [1:0] ps;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  instr_shift_register dut (
    .clk            (clk),
    .rst            (rst),
    .ser_in         (ser_in),
    .ser_en         (ser_en),
    .word_start     (word_start),
    .consume        (consume),
    .ready          (ready),
    .instr_valid    (instr_valid),
    .instr_addr     (instr_addr),
    .instr_b        (instr_b),
    .instr_spare    (instr_spare),
    .instr_func     (instr_func),
    .ps             (ps),
    .action_trigger (action_trigger),
    .framing_err    (framing_err),
    .overrun_err    (overrun_err),
    .state_dbg      (state_dbg)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 collecting bits, 2 holding an instruction
  int  m_mode = 0;
  int  m_bits = 0;
  int  m_word = 0;
  int  m_hold = 0;
  int  m_addr = 0, m_b = 0, m_spare = 0, m_func = 0;
  bit  m_fe = 0, m_oe = 0;
  bit  model_live = 0;

  always @(posedge clk) begin
    if (rst) begin
      model_live = 1;
      m_mode = 0; m_bits = 0; m_word = 0; m_hold = 0;
      m_addr = 0; m_b = 0; m_spare = 0; m_func = 0;
      m_fe = 0; m_oe = 0;
    end else begin
      m_fe = 0;
      m_oe = 0;
      if (m_mode == 0) begin
        if (ser_en && word_start) begin
          m_word = int'(ser_in);
          m_bits = 1;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (ser_en && word_start) begin
          m_word = int'(ser_in);
          m_bits = 1;
          m_fe = 1;
        end else if (ser_en) begin
          m_word = m_word + (int'(ser_in) << m_bits);
          m_bits++;
          if (m_bits == 20) begin
            m_mode  = 2;
            m_hold  = 0;
            m_addr  = m_word % 1024;
            m_b     = (m_word / 1024) % 8;
            m_spare = (m_word / 8192) % 2;
            m_func  = m_word / 16384;
          end
        end
      end else begin
        if (ser_en && word_start) m_oe = 1;
        if (consume) begin
          m_mode = 0;
          m_hold = 0;
        end else begin
          m_hold++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_fe = 0;
  int n_oe = 0;

  always @(negedge clk) begin
    if (model_live) begin
      check("ready",       ready,          m_mode == 0);
      check("instr_valid", instr_valid,    m_mode == 2);
      check("ps",          ps,             (m_mode == 2) ? (m_hold % 4) : 0);
      check("trigger",     action_trigger, (m_mode == 2) && (m_hold % 4 == 3));
      check("framing_err", framing_err,    m_fe);
      check("overrun_err", overrun_err,    m_oe);
      check("addr",        instr_addr,     m_addr);
      check("b",           instr_b,        m_b);
      check("spare",       instr_spare,    m_spare);
      check("func",        instr_func,     m_func);
      check("state",       state_dbg,
            (m_mode == 0) ? ST_IDLE : (m_mode == 1) ? ST_SHIFT : ST_HOLD);
      if (framing_err === 1'b1) n_fe++;
      if (overrun_err === 1'b1) n_oe++;
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs are applied, held across one rising edge, and the task returns
  // 2 time units after that edge so outputs can be inspected.
  task automatic tick(input logic r, input logic en, input logic din,
                      input logic ws, input logic cons);
    rst = r; ser_en = en; ser_in = din; word_start = ws; consume = cons;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0);
  endtask

  // Send nbits of w, LSB first; gap cycles of noise between bits.
  task automatic send_word(input logic [19:0] w, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      tick(0, 1, w[i], i == 0, 0);
      if (i != nbits - 1) begin
        for (int g = 0; g < gap; g++) tick(0, 0, 1, 1, 1);
      end
    end
  endtask

  int exp_ps[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

  // ---------------- directed stimulus ----------------
  initial begin
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("rst_ready", ready, 1);
    check("rst_valid", instr_valid, 0);
    check("rst_addr",  instr_addr, 0);
    check("rst_ps",    ps, 0);

    // Bits without word_start in IDLE are ignored.
    tick(0, 1, 1, 0, 1);
    tick(0, 1, 1, 0, 0);
    check("idle_ignore_ready", ready, 1);

    // Continuous 0xABCDE.
    send_word(20'hABCDE, 20, 0);
    check("w1_valid", instr_valid, 1);
    check("w1_addr",  instr_addr, 10'h0DE);
    check("w1_b",     instr_b, 7);
    check("w1_spare", instr_spare, 1);
    check("w1_func",  instr_func, 6'h2A);
    check("model_addr", m_addr, 10'h0DE);
    check("model_func", m_func, 6'h2A);

    // Nine HOLD cycles: stage count and final-stage pulse.
    for (int c = 0; c < 9; c++) begin
      check("hold_ps",      ps, exp_ps[c]);
      check("hold_trigger", action_trigger, exp_ps[c] == 3);
      idle();
    end
    tick(0, 0, 0, 0, 1);
    check("consume_ready", ready, 1);
    check("consume_valid", instr_valid, 0);
    check("consume_ps",    ps, 0);

    // Restart at bit 7, then 0x00001.
    n_fe = 0;
    n_oe = 0;
    send_word(20'h00055, 7, 0);
    send_word(20'h00001, 20, 0);
    check("frame_count", n_fe, 1);
    check("frame_valid", instr_valid, 1);
    check("frame_addr",  instr_addr, 1);
    check("frame_func",  instr_func, 0);
    tick(0, 0, 0, 0, 1);

    // Overrun during HOLD.
    send_word(20'h12345, 20, 0);
    n_oe = 0;
    tick(0, 1, 1, 1, 0);
    check("overrun_pulse", overrun_err, 1);
    check("overrun_addr",  instr_addr, 10'h345);
    check("overrun_func",  instr_func, 4);
    idle();
    check("overrun_end",   overrun_err, 0);
    check("overrun_count", n_oe, 1);
    tick(0, 0, 0, 0, 1);
    check("overrun_ready", ready, 1);

    // Reset mid-word after bit 12.
    send_word(20'hABCDE, 13, 0);
    tick(1, 1, 1, 0, 0);
    check("midrst_ready", ready, 1);
    check("midrst_valid", instr_valid, 0);
    check("midrst_addr",  instr_addr, 0);
    check("midrst_func",  instr_func, 0);
    idle();
    send_word(20'hFFFFF, 20, 0);
    check("ones_addr",  instr_addr, 10'h3FF);
    check("ones_b",     instr_b, 7);
    check("ones_spare", instr_spare, 1);
    check("ones_func",  instr_func, 6'h3F);
    tick(0, 0, 0, 0, 1);

    // Gapped 0xABCDE with noise (en=0) and stray consume between bits.
    n_fe = 0;
    n_oe = 0;
    send_word(20'hABCDE, 20, 3);
    check("gap_valid", instr_valid, 1);
    check("gap_addr",  instr_addr, 10'h0DE);
    check("gap_b",     instr_b, 7);
    check("gap_spare", instr_spare, 1);
    check("gap_func",  instr_func, 6'h2A);
    check("gap_fe",    n_fe, 0);
    check("gap_oe",    n_oe, 0);
    tick(0, 0, 0, 0, 1);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_shift_register.md
INSTR_SHIFT_REGISTER -- requirements
Module: instr_shift_register

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 20, bits per serial word.
REQ-002 SHALL have parameters ADDR_BITS=10, B_BITS=3, SPARE_BITS=1, FUNC_BITS=6, field widths summing to WORD_LENGTH.
REQ-003 SHALL have parameter PS_BITS, default 2, width of the stage counter.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ser_in  in  1  serial instruction bit, LSB first.
REQ-007 SHALL have port ser_en  in  1  ser_in is valid this cycle.
REQ-008 SHALL have port word_start  in  1  qualifies the current ser_in bit as bit 0 of a new word (only when ser_en=1).
REQ-009 SHALL have port consume  in  1  downstream test unit has finished with the held instruction.
REQ-010 SHALL have port ready  out  1  block can accept a new word.
REQ-011 SHALL have port instr_valid  out  1  field outputs hold a complete instruction.
REQ-012 SHALL have ports instr_addr out 10, instr_b out 3, instr_spare out 1, instr_func out 6.
REQ-013 SHALL have port ps  out  PS_BITS  stage count fed to the downstream test unit.
REQ-014 SHALL have port action_trigger  out  1  one-cycle pulse at the final stage.
REQ-015 SHALL have ports framing_err out 1 and overrun_err out 1, one-cycle error pulses.

Function
REQ-016 SHALL implement states IDLE, SHIFT, HOLD.
REQ-017 IDLE: ready=1; on ser_en&word_start SHALL store ser_in to word[0], set bit count=1, go to SHIFT; ser_en without word_start SHALL be ignored.
REQ-018 SHIFT: on ser_en&!word_start SHALL store ser_in to word[count] and increment count; cycles with ser_en=0 SHALL hold state.
REQ-019 SHIFT: when bit WORD_LENGTH-1 is stored, state SHALL be HOLD and instr_valid=1 on the next cycle (1-cycle latency).
REQ-020 SHIFT: ser_en&word_start SHALL restart the word (bit to word[0], count=1) and pulse framing_err for one cycle.
REQ-021 Field mapping: addr=word[9:0], b=word[12:10], spare=word[13], func=word[19:14].
REQ-022 Field outputs SHALL change only on entry to HOLD and otherwise hold their last values.
REQ-023 HOLD: ps SHALL start at 0 on HOLD entry and increment by 1 each cycle, wrapping 3->0.
REQ-024 HOLD: action_trigger SHALL be 1 exactly in cycles where ps=3; it SHALL be 0 outside HOLD.
REQ-025 HOLD: consume=1 SHALL clear instr_valid and return to IDLE next cycle; ps SHALL reset to 0.
REQ-026 HOLD: ser_en&word_start SHALL be dropped and pulse overrun_err; held fields SHALL be unaffected.
REQ-027 consume in IDLE or SHIFT SHALL be ignored.
REQ-028 ready SHALL be 1 only in IDLE.

Reset
REQ-029 rst=1 SHALL force IDLE, count=0, word=0, all field outputs 0, ps=0, instr_valid=0, action_trigger=0, framing_err=0, overrun_err=0, ready=1 on the next edge.
REQ-030 rst SHALL override all other inputs, including mid-word and mid-HOLD; the partial word SHALL be discarded.

Structure
REQ-031 Field widths, field offsets and the state encoding SHALL live in the shared data-flow package used by the test unit.
REQ-032 The ps/action_trigger generator SHALL be a sub-module named stage_counter; the rest SHALL be flat.

Verification
REQ-033 Shift 0xABCDE (20 bits, LSB first, ser_en continuous) -> instr_valid next cycle; addr=0x0DE, b=7, spare=1, func=0x2A.
REQ-034 Hold in HOLD 9 cycles -> ps 0,1,2,3,0,1,2,3,0; action_trigger high in cycles 4 and 8 only.
REQ-035 word_start at bit 7 of a word, then 20 bits of 0x00001 -> framing_err one pulse; addr=1, func=0.
REQ-036 word_start with ser_en during HOLD -> overrun_err one pulse; fields unchanged; consume -> IDLE, ready=1.
REQ-037 rst asserted after bit 12 of a word -> all outputs 0, ready=1; next full word 0xFFFFF decodes addr=0x3FF, b=7, spare=1, func=0x3F.
REQ-038 ser_en gaps of 3 cycles between every bit of 0xABCDE -> same fields as REQ-033, no error pulses.
